wb_arbiter2: RTL
================

# wb_arbiter2

Two-master, one-slave round-robin arbiter for the pipelined Wishbone fabric. It lets the Ibex instruction and data ports, or any two `wb_if` masters, share one downstream `wb_if` slave, such as memory or the debug-module bridge. A granted master owns the slave until it drops `cyc`. Accepted requests are counted so that the number of outstanding transfers is bounded, and so that the arbiter can tell when the bus is quiet.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unacknowledged transfers per grant, 1..15.

Ports:
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `m0`  wb_if.slave  interface widths  requester 0 (instruction port).
- `m1`  wb_if.slave  interface widths  requester 1 (data port).
- `s`  wb_if.master  interface widths  shared downstream slave.

The already-decided parameters are one clock, `clk`, and reset `rst`, which is synchronous and active-high. The `clk`/`rst` members inside the interfaces are driven from these ports.

## Operation
- The FSM has three states: IDLE, GNT0 and GNT1. A 4-bit counter `outst` and a priority pointer `last` (1 bit, the master granted most recently) support it.
- **IDLE:**
  - A request is `mX.cyc & mX.stb`.
  - A sole requester is granted.
  - If both request, the master ≠ `last` is granted.
  - The state moves to GNTx on the next edge, and `last` ← x.
- **GNTx:**
  - Downstream outputs are driven from `mX`:
    - `s.cyc = mX.cyc`
    - `s.stb = mX.stb & ~full`
    - `s.we`, `s.adr`, `s.sel` and `s.dat_o` are passed through from `mX`.
  - Returns to `mX`:
    - `mX.dat_i = s.dat_i`
    - `mX.ack = s.ack`
    - `mX.err = s.err`
    - `mX.stall = s.stall | full`
  - `full = (outst == MAX_OUTSTANDING)`.
  - `accept = s.cyc & s.stb & ~s.stall`.
  - `done = s.ack | s.err`.
  - Counter update:
    - `outst` += `accept` − `done`.
    - A simultaneous accept and done leaves `outst` unchanged.
    - A done with `outst == 0` is ignored, so the counter never underflows.
  - The grant is released when `mX.cyc == 0`: the state goes to IDLE and `outst` ← 0.
- **Non-granted master:**
  - `stall = 1`, `ack = 0`, `err = 0`, `dat_i = 0`.
- **In IDLE:**
  - All `s` outputs are 0.
  - Both masters see `stall = 1`.
- A master that drops `cyc` with transfers still outstanding abandons them, per the Wishbone rule. Late `ack`/`err` for that master are not forwarded.
- An `err` completes a transfer exactly as an `ack` does.

## Timing
- **Reset values** (asserted on the next `clk` edge with `rst` high; `rst` overrides everything, including mid-transfer):
  - State IDLE, `outst = 0`, `last = 1` (so m0 wins the first tie).
  - `s.cyc`, `s.stb`, `s.we`, `s.adr`, `s.sel` and `s.dat_o` are all 0.
  - `m0.stall` and `m1.stall` are 1; all master `ack`/`err`/`dat_i` are 0.
- **Grant latency:** 1 cycle. A request in cycle N appears on `s.stb` in cycle N+1 if the arbiter was IDLE in cycle N.
- **Handover:** when `cyc` drops in cycle N, the arbiter is IDLE in N+1 and the next grant is active in N+2. The minimum bus gap is 1 cycle.
- **Data path:** once granted, the path is purely combinational and adds no latency.
- **Back-to-back throughput:** 1 transfer/cycle until `full`.
  - `full` stalls the master in the same cycle, combinationally.
  - The first `done` drops `full` in the following cycle.

## Configuration
- `WB_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority. On a tie in IDLE, m0 always wins and `last` is ignored.
  - **Undefined (default):** round-robin as described above.
  - Grant holding, counting and all timing are identical in both builds.

## Test plan
- **Reset mid-transfer:** m0 is granted with `outst = 2`, then `rst` is held for 1 cycle → next cycle IDLE, `outst = 0`, `s.cyc = 0`, both `stall = 1`.
- **Tie arbitration:** m0 and m1 raise `cyc`/`stb` in the same cycle just after reset → GNT0. m0 drops `cyc` → IDLE, then GNT1 two cycles after the drop. A second simultaneous tie → GNT0. With `WB_ARB_FIXED_PRIO_EN` defined, every tie → GNT0.
- **Outstanding limit:** `MAX_OUTSTANDING = 2`, slave never stalls and acks after 3 cycles, m1 streams 5 reads → `m1.stall = 1` after the 2nd accept, released the cycle after each ack; exactly 5 acks reach m1 and m0 sees none.
- **Simultaneous accept and ack:** with `outst = 1`, accept and ack occur in the same cycle → `outst` stays 1; the data matches `s.dat_i` on `m0.dat_i`.
- **Error propagation:** slave returns `err` on the 2nd of 3 writes → `m0.err` pulses exactly once, `outst` decrements, and the 3rd write completes normally.
- **Abandon:** m1 drops `cyc` with `outst = 1` and m0 is waiting → the late `s.ack` is not seen on `m1.ack` or `m0.ack`, and m0 is granted 2 cycles after the drop.

Source files
------------

// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bundle shared by the arbiter, its two requesters and the slave.
// dat_o carries write data from the master; dat_i carries read data back to it.
interface wb_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
) (
    input logic clk,
    input logic rst
);
    logic               cyc;
    logic               stb;
    logic               we;
    logic [ADR_W-1:0]   adr;
    logic [DAT_W/8-1:0] sel;
    logic [DAT_W-1:0]   dat_o;
    logic [DAT_W-1:0]   dat_i;
    logic               ack;
    logic               err;
    logic               stall;

    modport master (
        input  clk, rst, dat_i, ack, err, stall,
        output cyc, stb, we, adr, sel, dat_o
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_o,
        output dat_i, ack, err, stall
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter; a grant is held until the owner drops cyc.
// Define WB_ARB_FIXED_PRIO_EN to make m0 win every tie instead of alternating.
module wb_arbiter2 #(
    parameter int MAX_OUTSTANDING = 4
) (
    input logic  clk,
    input logic  rst,
    wb_if.slave  m0,
    wb_if.slave  m1,
    wb_if.master s
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_outst;
    logic       r_last;
    logic       w_req0;
    logic       w_req1;
    logic       w_tieTo1;
    logic       w_full;
    logic       w_accept;
    logic       w_done;

    assign w_req0   = m0.cyc & m0.stb;
    assign w_req1   = m1.cyc & m1.stb;
    assign w_full   = (r_outst == 4'(MAX_OUTSTANDING));
    assign w_accept = s.cyc & s.stb & ~s.stall;
    assign w_done   = s.ack | s.err;

`ifdef WB_ARB_FIXED_PRIO_EN
    assign w_tieTo1 = 1'b0;
`else
    assign w_tieTo1 = ~r_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == GNT0) begin
                r_last <= 1'b0;
            end else if (w_next == GNT1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Outstanding count is per grant: cleared on release, underflow-protected.
    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE || w_next == IDLE) begin
            r_outst <= 4'd0;
        end else if (w_accept && !w_done) begin
            r_outst <= r_outst + 4'd1;
        end else if (w_done && !w_accept && r_outst != 4'd0) begin
            r_outst <= r_outst - 4'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = w_tieTo1 ? GNT1 : GNT0;
                end else if (w_req0) begin
                    w_next = GNT0;
                end else if (w_req1) begin
                    w_next = GNT1;
                end
            end
            GNT0:    if (!m0.cyc) w_next = IDLE;
            GNT1:    if (!m1.cyc) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.sel    = '0;
        s.dat_o  = '0;
        m0.dat_i = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.stall = 1'b1;
        m1.dat_i = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.stall = 1'b1;
        case (r_state)
            GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb & ~w_full;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.sel    = m0.sel;
                s.dat_o  = m0.dat_o;
                m0.dat_i = s.dat_i;
                m0.ack   = s.ack;
                m0.err   = s.err;
                m0.stall = s.stall | w_full;
            end
            GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb & ~w_full;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.sel    = m1.sel;
                s.dat_o  = m1.dat_o;
                m1.dat_i = s.dat_i;
                m1.ack   = s.ack;
                m1.err   = s.err;
                m1.stall = s.stall | w_full;
            end
            default: begin
            end
        endcase
    end
endmodule
